// File: rtl/simple_pkg.sv
// Shared constants and types for the simple_out_deser serial-to-word capture block.
package simple_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_CNT_W = 16;

  // Saturation value of the toggle counter at its default width.
  localparam logic [DEF_CNT_W-1:0] DEF_CNT_MAX = '1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ofsm_e;

endpackage

// File: rtl/simple_toggle_cnt.sv
// Activity monitor: counts sampled transitions of a serial bit, saturating at all-ones.
module simple_toggle_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             bit_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    prev_d = prev_q;
    cnt_d  = cnt_q;
    if (en_i) begin
      prev_d = bit_i;
      if ((bit_i != prev_q) && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // prev starts at 0, so a first sampled 1 counts as a transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/simple_out_deser.sv
// Packs the serial benchmark output LSB-first into words and offers them on a
// registered valid/ready port, with a sticky drop flag and a transition counter.
module simple_out_deser
  import simple_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int CNT_W = DEF_CNT_W,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             tau2015_clk,
  input  logic             tau2015_rst_n,
  input  logic             ser_in,
  input  logic             en,
  output logic [WIDTH-1:0] word_data,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             overflow,
  input  logic             clr_ovf,
  output logic [IDX_W-1:0] bit_idx,
  output logic [CNT_W-1:0] toggle_cnt
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [WIDTH-1:0] word_data_q, word_data_d;
  logic             overflow_q, overflow_d;
  ofsm_e            state_q, state_d;
  logic             complete;
  logic [WIDTH-1:0] done_word;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    complete  = en && (bit_idx_q == LAST_IDX);
    done_word = shift_q;
    done_word[WIDTH-1] = ser_in;
    if (en) begin
      shift_d[bit_idx_q] = ser_in;
      bit_idx_d = complete ? '0 : bit_idx_q + 1'b1;
    end
  end

  // A completion while FULL is only accepted if the held word leaves this cycle.
  always_comb begin
    state_d     = state_q;
    word_data_d = word_data_q;
    overflow_d  = clr_ovf ? 1'b0 : overflow_q;
    unique case (state_q)
      EMPTY: begin
        if (complete) begin
          word_data_d = done_word;
          state_d     = FULL;
        end
      end
      FULL: begin
        if (word_ready) begin
          if (complete) begin
            word_data_d = done_word;
          end else begin
            state_d = EMPTY;
          end
        end else if (complete) begin
          overflow_d = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge tau2015_clk or negedge tau2015_rst_n) begin
    if (!tau2015_rst_n) begin
      shift_q     <= '0;
      bit_idx_q   <= '0;
      word_data_q <= '0;
      overflow_q  <= 1'b0;
      state_q     <= EMPTY;
    end else begin
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      word_data_q <= word_data_d;
      overflow_q  <= overflow_d;
      state_q     <= state_d;
    end
  end

  simple_toggle_cnt #(
    .CNT_W(CNT_W)
  ) u_toggle_cnt (
    .clk   (tau2015_clk),
    .rst_n (tau2015_rst_n),
    .en_i  (en),
    .bit_i (ser_in),
    .cnt_o (toggle_cnt)
  );

  assign word_data  = word_data_q;
  assign word_valid = (state_q == FULL);
  assign overflow   = overflow_q;
  assign bit_idx    = bit_idx_q;

endmodule

// File: tb/tb_simple_out_deser.sv
// Directed bench for simple_out_deser: stimulus pushes expected words, a monitor
// pops and compares them on every valid/ready handshake.
module tb_simple_out_deser;
  import simple_pkg::*;

  logic        tau2015_clk;
  logic        tau2015_rst_n;
  logic        ser_in;
  logic        en;
  logic [7:0]  word_data;
  logic        word_valid;
  logic        word_ready;
  logic        overflow;
  logic        clr_ovf;
  logic [2:0]  bit_idx;
  logic [15:0] toggle_cnt;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] sb[$];

  simple_out_deser dut (
    .tau2015_clk   (tau2015_clk),
    .tau2015_rst_n (tau2015_rst_n),
    .ser_in        (ser_in),
    .en            (en),
    .word_data     (word_data),
    .word_valid    (word_valid),
    .word_ready    (word_ready),
    .overflow      (overflow),
    .clr_ovf       (clr_ovf),
    .bit_idx       (bit_idx),
    .toggle_cnt    (toggle_cnt)
  );

  initial tau2015_clk = 1'b0;
  always #5 tau2015_clk = ~tau2015_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Handshake fires on the next rising edge; inputs only change just after posedge.
  always @(negedge tau2015_clk) begin
    if (tau2015_rst_n && word_valid && word_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_word: got 0x%0h, expected no word", word_data);
      end else begin
        check("word_data", {24'h0, word_data}, {24'h0, sb.pop_front()});
      end
    end
  end

  task automatic step(input logic b, input logic e, input logic rdy);
    ser_in     = b;
    en         = e;
    word_ready = rdy;
    @(posedge tau2015_clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w, input logic rdy, input logic rdy_last);
    for (int i = 0; i < 8; i++) step(w[i], 1'b1, (i == 7) ? rdy_last : rdy);
  endtask

  task automatic do_reset();
    tau2015_rst_n = 1'b0;
    ser_in = 1'b0; en = 1'b0; word_ready = 1'b0; clr_ovf = 1'b0;
    repeat (2) @(posedge tau2015_clk);
    #1;
    tau2015_rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    check("rst_valid", {31'h0, word_valid}, 32'h0);
    check("rst_data", {24'h0, word_data}, 32'h0);
    check("rst_ovf", {31'h0, overflow}, 32'h0);
    check("rst_idx", {29'h0, bit_idx}, 32'h0);
    check("rst_tog", {16'h0, toggle_cnt}, 32'h0);

    // Basic word 0x4D with the consumer ready.
    sb.push_back(8'h4D);
    send_word(8'h4D, 1'b1, 1'b1);
    check("w1_valid", {31'h0, word_valid}, 32'h1);
    check("w1_idx", {29'h0, bit_idx}, 32'h0);
    check("w1_ovf", {31'h0, overflow}, 32'h0);
    check("w1_tog", {16'h0, toggle_cnt}, 32'd6);
    step(1'b0, 1'b0, 1'b1);
    check("w1_pulse", {31'h0, word_valid}, 32'h0);

    // Back-to-back 0xFF then 0x00 with no consumer: second word dropped.
    sb.push_back(8'hFF);
    send_word(8'hFF, 1'b0, 1'b0);
    check("ff_valid", {31'h0, word_valid}, 32'h1);
    check("ff_data", {24'h0, word_data}, 32'hFF);
    send_word(8'h00, 1'b0, 1'b0);
    check("drop_ovf", {31'h0, overflow}, 32'h1);
    check("drop_data", {24'h0, word_data}, 32'hFF);
    check("drop_valid", {31'h0, word_valid}, 32'h1);
    check("drop_tog", {16'h0, toggle_cnt}, 32'd8);
    clr_ovf = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    clr_ovf = 1'b0;
    check("clr_ovf", {31'h0, overflow}, 32'h0);
    check("clr_valid", {31'h0, word_valid}, 32'h1);
    step(1'b0, 1'b0, 1'b1);
    check("ff_drained", {31'h0, word_valid}, 32'h0);

    // 0xA5 held, then 0x3C completes on the same edge the consumer takes 0xA5.
    sb.push_back(8'hA5);
    send_word(8'hA5, 1'b0, 1'b0);
    check("a5_data", {24'h0, word_data}, 32'hA5);
    sb.push_back(8'h3C);
    send_word(8'h3C, 1'b0, 1'b1);
    check("swap_data", {24'h0, word_data}, 32'h3C);
    check("swap_valid", {31'h0, word_valid}, 32'h1);
    check("swap_ovf", {31'h0, overflow}, 32'h0);
    check("swap_tog", {16'h0, toggle_cnt}, 32'd18);
    step(1'b0, 1'b0, 1'b1);
    check("swap_drained", {31'h0, word_valid}, 32'h0);

    // 0x96 with a 5-cycle enable gap after 3 bits; ser_in wiggles during the gap.
    sb.push_back(8'h96);
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    check("gap_idx0", {29'h0, bit_idx}, 32'd3);
    check("gap_tog0", {16'h0, toggle_cnt}, 32'd19);
    for (int i = 0; i < 5; i++) step(i[0], 1'b0, 1'b1);
    check("gap_idx", {29'h0, bit_idx}, 32'd3);
    check("gap_tog", {16'h0, toggle_cnt}, 32'd19);
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    check("gap_early", {31'h0, word_valid}, 32'h0);
    step(1'b1, 1'b1, 1'b1);
    check("gap_valid", {31'h0, word_valid}, 32'h1);
    check("gap_idx_end", {29'h0, bit_idx}, 32'd0);
    check("gap_tog_end", {16'h0, toggle_cnt}, 32'd23);
    step(1'b0, 1'b0, 1'b1);

    // Reset asserted mid-cycle while FULL with 5 partial bits.
    send_word(8'h11, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
    check("pre_rst_idx", {29'h0, bit_idx}, 32'd5);
    check("pre_rst_valid", {31'h0, word_valid}, 32'h1);
    #2;
    tau2015_rst_n = 1'b0;
    en = 1'b0;
    #1;
    check("mid_rst_valid", {31'h0, word_valid}, 32'h0);
    check("mid_rst_data", {24'h0, word_data}, 32'h0);
    check("mid_rst_idx", {29'h0, bit_idx}, 32'h0);
    check("mid_rst_tog", {16'h0, toggle_cnt}, 32'h0);
    check("mid_rst_ovf", {31'h0, overflow}, 32'h0);
    @(posedge tau2015_clk);
    #1;
    tau2015_rst_n = 1'b1;
    sb.push_back(8'hC3);
    send_word(8'hC3, 1'b1, 1'b1);
    check("post_rst_valid", {31'h0, word_valid}, 32'h1);
    check("post_rst_idx", {29'h0, bit_idx}, 32'h0);
    check("post_rst_tog", {16'h0, toggle_cnt}, 32'd3);
    step(1'b0, 1'b0, 1'b1);

    // Toggle-counter saturation: alternate 1,0,... from a fresh reset.
    do_reset();
    for (int i = 0; i < 65600; i++) begin
      if ((i % 8) == 7) sb.push_back(8'h55);
      step(~i[0], 1'b1, 1'b1);
      if (i == 65533) check("sat_pre", {16'h0, toggle_cnt}, 32'hFFFE);
    end
    check("sat_max", {16'h0, toggle_cnt}, {16'h0, DEF_CNT_MAX});
    repeat (3) step(1'b0, 1'b0, 1'b1);
    check("sat_hold", {16'h0, toggle_cnt}, 32'hFFFF);
    check("sb_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/simple_out_deser.md
Name: simple_out_deser

Overview:
- Downstream consumer of the single-bit `out` of the `simple` inverter-chain benchmark.
- Samples that serial bit on every enabled `tau2015_clk` edge and packs the bits LSB-first into WIDTH-bit words.
- Presents each word on a valid/ready output port and counts output transitions as an activity/sanity monitor.
- Provides a registered, handshaked observation point for pipelining experiments on the benchmark.

Parameters:
- WIDTH, 8, bits per assembled word (2..32)
- CNT_W, 16, width of the saturating toggle counter
- IDX_W, $clog2(WIDTH), width of the bit-index counter (derived, not overridden)

Ports:
- tau2015_clk  input  1  single clock, rising edge
- tau2015_rst_n  input  1  asynchronous, active-low reset
- ser_in  input  1  serial bit, driven by `out` of `simple`
- en  input  1  sample enable; when low, all capture and counting freezes
- word_data  output  WIDTH  assembled word; ser_in bit 0 sits in bit 0
- word_valid  output  1  word_data holds an unconsumed word
- word_ready  input  1  consumer accepts the word on a cycle with word_valid=1
- overflow  output  1  sticky flag: a completed word was dropped
- clr_ovf  input  1  synchronous clear of overflow
- bit_idx  output  IDX_W  number of bits captured toward the current word
- toggle_cnt  output  CNT_W  saturating count of sampled ser_in transitions

Behaviour:
- Reset (async assert, sync-released by the environment) clears all state to 0: shift register, bit_idx, word_data, word_valid, overflow, toggle_cnt, prev_bit, and FSM state = EMPTY.
- Capture, on each rising edge with en=1:
  - ser_in is shifted into shift_reg[bit_idx].
  - bit_idx increments, wrapping from WIDTH-1 to 0.
  - With en=0, shift_reg, bit_idx, prev_bit and toggle_cnt hold.
- Word completion: an edge with en=1 and bit_idx==WIDTH-1. The completed word = shift_reg with the current ser_in in bit WIDTH-1.
- Output FSM, two states:
  - EMPTY (word_valid=0): on completion, load word_data and go to FULL.
  - FULL (word_valid=1):
    - word_ready=1 and no completion: go to EMPTY. word_data keeps its last value.
    - word_ready=1 with completion in the same cycle: load the new word and stay FULL. No bubble, no overflow.
    - word_ready=0 with completion: drop the new word, keep the old word_data, set overflow=1, stay FULL.
- Latency: word_valid rises on the same edge that captures the WIDTH-th bit. Data is visible the following cycle. The handshake completes on the edge where valid and ready are both 1.
- word_data and word_valid are stable while word_valid=1 and word_ready=0.
- overflow:
  - Sticky. Cleared by clr_ovf=1 on an edge.
  - If clr_ovf and a new drop occur on the same edge, the set wins (overflow=1).
- Toggle counter (en=1 edges only):
  - If ser_in != prev_bit, toggle_cnt increments, saturating at 2^CNT_W-1.
  - prev_bit <= ser_in.
  - prev_bit resets to 0, so a first sampled 1 counts as one toggle.
- word_ready while word_valid=0 is ignored.
- Reset asserted mid-word discards partial bits. Reset while FULL discards the held word. No output glitches beyond the async clear.
- Outputs: word_data, word_valid, overflow, bit_idx and toggle_cnt are all registered. No combinational input-to-output path.

Decomposition:
- Package simple_pkg holds:
  - default WIDTH and CNT_W constants;
  - the output-FSM enum (EMPTY=1'b0, FULL=1'b1);
  - a localparam for the toggle-counter max.
- Sub-module simple_toggle_cnt (prev_bit register plus saturating counter with enable) is natural and is instantiated once.

Test Plan:
- Reset then en=1, ser_in = 1,0,1,1,0,0,1,0 (LSB first), word_ready=1 -> word_valid pulses 1 cycle, word_data=8'h4D, overflow=0, bit_idx back to 0.
- Two back-to-back words 8'hFF then 8'h00, word_ready held 0 -> first word held, second dropped, overflow=1, word_data=8'hFF. Then clr_ovf=1 for one cycle -> overflow=0.
- Word completion on the same edge as word_ready=1 while FULL with 8'hA5 -> word_data becomes the new word 8'h3C, word_valid stays 1, overflow=0.
- en toggled low for 5 cycles mid-word after 3 bits -> bit_idx holds at 3 and toggle_cnt holds. The word completes after exactly 5 further enabled bits with correct contents.
- ser_in alternating 0/1 for 70000 enabled cycles with CNT_W=16 -> toggle_cnt saturates at 16'hFFFF and does not wrap.
- Assert tau2015_rst_n low mid-cycle while FULL and bit_idx=5 -> all outputs 0 immediately. After release, the next 8 bits form a fresh word.
